// File: rtl/ps2_kbd_rx_if.sv
// PS/2 keyboard receiver bus: raw keyboard lines in, decoded byte/flags out.
// master = keyboard/consumer side, slave = ps2_kbd_rx.
interface ps2_kbd_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic       ctrl1;
    logic       ctrl2;
    logic       ctrl3;
    logic       ctrl4;

    modport master (
        output ps2_clk, ps2_data,
        input  scan_code, code_valid, frame_err,
        input  ctrl1, ctrl2, ctrl3, ctrl4
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output scan_code, code_valid, frame_err,
        output ctrl1, ctrl2, ctrl3, ctrl4
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + debounce, 11-bit frame FSM, arrow/rotate decode.
// Ports: clk, reset (async active-low), bus (ps2_kbd_rx_if.slave).
// Macro PS2_KBD_RX_PARITY_CHECK_EN enables odd-parity checking.
module ps2_kbd_rx #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic        clk,
    input  logic        reset,
    ps2_kbd_rx_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          s_clk;
    logic          s_dat;
    logic          clk_f;
    logic [FW-1:0] fcnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          par_ok;
    logic          ext;
    logic          brk;
    logic [7:0]    scan_code;
    logic          code_valid;
    logic          frame_err;
    logic          ctrl1;
    logic          ctrl2;
    logic          ctrl3;
    logic          ctrl4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], bus.ps2_clk};
            dat_sync <= {dat_sync[0], bus.ps2_data};
        end
    end

    assign s_clk = clk_sync[1];
    assign s_dat = dat_sync[1];

    // Filtered level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_f <= 1'b1;
            fcnt  <= '0;
        end else if (s_clk == clk_f) begin
            fcnt <= '0;
        end else if (fcnt == FMAX) begin
            clk_f <= s_clk;
            fcnt  <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign fall = clk_f & ~s_clk & (fcnt == FMAX);

`ifdef PS2_KBD_RX_PARITY_CHECK_EN
    logic par;
    assign par_ok = ^{shreg, par};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bcnt       <= '0;
            shreg      <= '0;
            tcnt       <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            scan_code  <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            ctrl1      <= 1'b0;
            ctrl2      <= 1'b0;
            ctrl3      <= 1'b0;
            ctrl4      <= 1'b0;
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
            par        <= 1'b0;
`endif
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE || fall) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;

            if (state != IDLE && !fall && tcnt == TMAX) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!s_dat) begin
                            state <= DATA;
                            bcnt  <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= {s_dat, shreg[7:1]};
                        bcnt  <= bcnt + 1'b1;
                        if (bcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
                        par <= s_dat;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (s_dat && par_ok) begin
                            scan_code  <= shreg;
                            code_valid <= 1'b1;
                            unique case (1'b1)
                                shreg == 8'hE0: ext <= 1'b1;
                                shreg == 8'hF0: brk <= 1'b1;
                                default: begin
                                    ext <= 1'b0;
                                    brk <= 1'b0;
                                    if (ext) begin
                                        case (shreg)
                                            8'h6B:   ctrl1 <= ~brk;
                                            8'h74:   ctrl2 <= ~brk;
                                            8'h72:   ctrl3 <= ~brk;
                                            8'h75:   ctrl4 <= ~brk;
                                            default: ;
                                        endcase
                                    end
                                end
                            endcase
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.scan_code  = scan_code;
    assign bus.code_valid = code_valid;
    assign bus.frame_err  = frame_err;
    assign bus.ctrl1      = ctrl1;
    assign bus.ctrl2      = ctrl2;
    assign bus.ctrl3      = ctrl3;
    assign bus.ctrl4      = ctrl4;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, break codes, errors, timeout, reset.
// Timeout scaled down so the run stays short.
module tb_ps2_kbd_rx;
    localparam int TO   = 2000;
    localparam int HALF = 30;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cv_hi = 0;
    int   err_hi = 0;
    int   cv0;
    int   err0;

    ps2_kbd_rx_if bus ();

    ps2_kbd_rx #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle-high counts: a one-cycle pulse adds exactly one.
    always @(posedge clk) begin
        if (bus.code_valid === 1'b1) cv_hi <= cv_hi + 1;
        if (bus.frame_err === 1'b1) err_hi <= err_hi + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic d);
        bus.ps2_data = d;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b0;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit stp, input int nb);
        logic [10:0] f;
        f = {stp, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nb; i++) send_bit(f[i]);
        wait_cyc(HALF);
        bus.ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic snap();
        cv0  = cv_hi;
        err0 = err_hi;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b0;
        wait_cyc(5);
        o = {bus.scan_code, bus.code_valid, bus.frame_err};
        n_chk++;
        if (o !== 11'd0 || {bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h/%b want 0", o,
                     {bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4});
        end
        reset = 1'b1;
        wait_cyc(20);
        n_chk++;
        if (cv_hi !== 0 || err_hi !== 0) begin
            n_fail++;
            $display("FAIL reset_pulses: got cv=%0d err=%0d want 0", cv_hi, err_hi);
        end
    endtask

    task automatic test_make();
        snap();
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'h6B, 0, 1, 11);
        n_chk++;
        if (cv_hi - cv0 !== 2 || err_hi !== err0) begin
            n_fail++;
            $display("FAIL make_pulses: got cv=%0d err=%0d want 2/0", cv_hi - cv0, err_hi - err0);
        end
        n_chk++;
        if (bus.scan_code !== 8'h6B || bus.ctrl1 !== 1'b1) begin
            n_fail++;
            $display("FAIL make_ctrl1: got %h/%b want 6b/1", bus.scan_code, bus.ctrl1);
        end
    endtask

    task automatic test_break();
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'hF0, 0, 1, 11);
        send_frame(8'h6B, 0, 1, 11);
        n_chk++;
        if ({bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4} !== 4'b0000) begin
            n_fail++;
            $display("FAIL break_ctrl: got %b want 0000",
                     {bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4});
        end
    endtask

    task automatic test_parity();
        snap();
        send_frame(8'h1C, 1, 1, 11);
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
        n_chk++;
        if (cv_hi !== cv0 || err_hi - err0 !== 1 || bus.scan_code !== 8'h6B) begin
            n_fail++;
            $display("FAIL parity_bad: got cv=%0d err=%0d sc=%h want 0/1/6b",
                     cv_hi - cv0, err_hi - err0, bus.scan_code);
        end
`else
        n_chk++;
        if (cv_hi - cv0 !== 1 || err_hi !== err0 || bus.scan_code !== 8'h1C) begin
            n_fail++;
            $display("FAIL parity_ign: got cv=%0d err=%0d sc=%h want 1/0/1c",
                     cv_hi - cv0, err_hi - err0, bus.scan_code);
        end
`endif
        snap();
        send_frame(8'h1C, 0, 1, 11);
        n_chk++;
        if (cv_hi - cv0 !== 1 || err_hi !== err0 || bus.scan_code !== 8'h1C) begin
            n_fail++;
            $display("FAIL parity_good: got cv=%0d err=%0d sc=%h want 1/0/1c",
                     cv_hi - cv0, err_hi - err0, bus.scan_code);
        end
    endtask

    task automatic test_bad_start();
        snap();
        send_bit(1'b1);
        wait_cyc(3 * HALF);
        n_chk++;
        if (err_hi - err0 !== 1 || cv_hi !== cv0) begin
            n_fail++;
            $display("FAIL bad_start: got err=%0d cv=%0d want 1/0", err_hi - err0, cv_hi - cv0);
        end
    endtask

    task automatic test_bad_stop();
        snap();
        send_frame(8'h5A, 0, 0, 11);
        n_chk++;
        if (err_hi - err0 !== 1 || cv_hi !== cv0 || bus.scan_code !== 8'h1C) begin
            n_fail++;
            $display("FAIL bad_stop: got err=%0d cv=%0d sc=%h want 1/0/1c",
                     err_hi - err0, cv_hi - cv0, bus.scan_code);
        end
    endtask

    task automatic test_timeout();
        snap();
        send_frame(8'h29, 0, 1, 5);
        wait_cyc(TO + TO / 5);
        n_chk++;
        if (err_hi - err0 !== 1 || cv_hi !== cv0) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%0d cv=%0d want 1/0", err_hi - err0, cv_hi - cv0);
        end
        snap();
        send_frame(8'h29, 0, 1, 11);
        n_chk++;
        if (cv_hi - cv0 !== 1 || err_hi !== err0 || bus.scan_code !== 8'h29) begin
            n_fail++;
            $display("FAIL timeout_next: got cv=%0d err=%0d sc=%h want 1/0/29",
                     cv_hi - cv0, err_hi - err0, bus.scan_code);
        end
    endtask

    task automatic test_glitch();
        snap();
        bus.ps2_clk = 1'b0;
        wait_cyc(3);
        bus.ps2_clk = 1'b1;
        wait_cyc(50);
        n_chk++;
        if (err_hi !== err0 || cv_hi !== cv0) begin
            n_fail++;
            $display("FAIL glitch: got err=%0d cv=%0d want 0/0", err_hi - err0, cv_hi - cv0);
        end
        send_frame(8'h1C, 0, 1, 11);
        n_chk++;
        if (cv_hi - cv0 !== 1 || bus.scan_code !== 8'h1C) begin
            n_fail++;
            $display("FAIL glitch_next: got cv=%0d sc=%h want 1/1c", cv_hi - cv0, bus.scan_code);
        end
    endtask

    task automatic test_discard_flags();
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h6B, 0, 1, 11);
        n_chk++;
        if (bus.ctrl1 !== 1'b1) begin
            n_fail++;
            $display("FAIL discard_flags: got ctrl1=%b want 1", bus.ctrl1);
        end
        send_frame(8'h6B, 0, 1, 11);
        send_frame(8'h75, 0, 1, 11);
        n_chk++;
        if ({bus.ctrl1, bus.ctrl4} !== 2'b10) begin
            n_fail++;
            $display("FAIL noext_keep: got %b want 10", {bus.ctrl1, bus.ctrl4});
        end
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'hF0, 0, 1, 11);
        send_frame(8'h6B, 0, 1, 11);
    endtask

    task automatic test_multi_ctrl();
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'h74, 0, 1, 11);
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'h6B, 0, 1, 11);
        n_chk++;
        if ({bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4} !== 4'b1100) begin
            n_fail++;
            $display("FAIL multi_ctrl: got %b want 1100",
                     {bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4});
        end
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'h6B, 0, 1, 11);
        n_chk++;
        if ({bus.ctrl1, bus.ctrl2} !== 2'b11) begin
            n_fail++;
            $display("FAIL typematic: got %b want 11", {bus.ctrl1, bus.ctrl2});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [14:0] o;
        send_frame(8'hE0, 0, 1, 4);
        bus.ps2_clk = 1'b0;
        wait_cyc(HALF);
        reset = 1'b0;
        wait_cyc(3);
        o = {bus.scan_code, bus.code_valid, bus.frame_err,
             bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4, 1'b0};
        n_chk++;
        if (o !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want 0", o);
        end
        bus.ps2_clk = 1'b1;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(40);
        snap();
        send_frame(8'hE0, 0, 1, 11);
        send_frame(8'h72, 0, 1, 11);
        n_chk++;
        if ({bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4} !== 4'b0010 ||
            bus.scan_code !== 8'h72 || cv_hi - cv0 !== 2 || err_hi !== err0) begin
            n_fail++;
            $display("FAIL reset_after: got %b sc=%h cv=%0d err=%0d want 0010/72/2/0",
                     {bus.ctrl1, bus.ctrl2, bus.ctrl3, bus.ctrl4},
                     bus.scan_code, cv_hi - cv0, err_hi - err0);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_parity();
        test_bad_start();
        test_bad_stop();
        test_timeout();
        test_glitch();
        test_discard_flags();
        test_multi_ctrl();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
